// File: rtl/serial_cmp_seq_pkg.sv
// Shared encodings and width helpers for the serial operand sequencers.
package serial_cmp_seq_pkg;

   localparam logic [1:0] SEQ_IDLE = 2'd0;
   localparam logic [1:0] SEQ_RUN  = 2'd1;
   localparam logic [1:0] SEQ_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = SEQ_IDLE,
      ST_RUN  = SEQ_RUN,
      ST_DONE = SEQ_DONE
   } seq_state_t;

   // Width needed to count from 0 up to npair inclusive.
   function automatic int unsigned cnt_width(input int unsigned npair);
      return $clog2(npair + 1);
   endfunction

endpackage

// File: rtl/serial_cmp_seq_if.sv
// Start/done request bus between a requester and the serial comparator.
interface serial_cmp_seq_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = serial_cmp_seq_pkg::cnt_width(WIDTH / 2);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             g;
   logic             e;
   logic             s;
   logic [CW-1:0]    pairs;

   modport master (
      output start, a, b,
      input  busy, done, g, e, s, pairs
   );

   modport slave (
      input  start, a, b,
      output busy, done, g, e, s, pairs
   );

endinterface

// File: rtl/serial_cmp_seq_cmp2_slice.sv
// Combinational 2-bit unsigned magnitude comparator built from two 1-bit compares.
module cmp2_slice (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       gt,
   output logic       eq,
   output logic       lt
);

   logic gt1, eq1, lt1;
   logic gt0, eq0, lt0;

   assign gt1 = x[1] & ~y[1];
   assign eq1 = ~(x[1] ^ y[1]);
   assign lt1 = ~x[1] & y[1];

   assign gt0 = x[0] & ~y[0];
   assign eq0 = ~(x[0] ^ y[0]);
   assign lt0 = ~x[0] & y[0];

   assign gt = gt1 | (eq1 & gt0);
   assign eq = eq1 & eq0;
   assign lt = lt1 | (eq1 & lt0);

endmodule

// File: rtl/serial_cmp_seq.sv
// MSB-first serial magnitude comparator: one 2-bit pair per cycle, stops at the
// first unequal pair and reports one-hot g/e/s plus the number of pairs examined.
module serial_cmp_seq
   import serial_cmp_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   serial_cmp_seq_if.slave bus
);

   localparam int unsigned NPAIR = WIDTH / 2;
   localparam int unsigned CW    = cnt_width(NPAIR);
   localparam int unsigned IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam int unsigned SW    = $clog2(WIDTH);

   seq_state_t       state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             g_q, g_d;
   logic             e_q, e_d;
   logic             s_q, s_d;

   logic [SW-1:0]    lsb;
   logic             sl_gt, sl_eq, sl_lt;

   // Low bit index of the pair currently selected by idx.
   assign lsb = SW'({idx_q, 1'b0});

   cmp2_slice u_slice (
      .x  (ra_q[lsb +: 2]),
      .y  (rb_q[lsb +: 2]),
      .gt (sl_gt),
      .eq (sl_eq),
      .lt (sl_lt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         g_q     <= 1'b0;
         e_q     <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         g_q     <= g_d;
         e_q     <= e_d;
         s_q     <= s_d;
      end
   end

   // Next state; a request is accepted in IDLE and in DONE (back-to-back).
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      g_d     = g_q;
      e_d     = e_q;
      s_d     = s_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               state_d = ST_RUN;
               ra_d    = bus.a;
               rb_d    = bus.b;
               idx_d   = IW'(NPAIR - 1);
               cnt_d   = '0;
               g_d     = 1'b0;
               e_d     = 1'b0;
               s_d     = 1'b0;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (sl_gt || sl_lt) begin
               state_d = ST_DONE;
               g_d     = sl_gt;
               s_d     = sl_lt;
               e_d     = 1'b0;
            end else if (idx_q == '0) begin
               state_d = ST_DONE;
               e_d     = sl_eq;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.g     = g_q;
   assign bus.e     = e_q;
   assign bus.s     = s_q;
   assign bus.pairs = cnt_q;

endmodule

// File: tb/tb_serial_cmp_seq.sv
// Directed bench for serial_cmp_seq at WIDTH 8, 2 and 16 sharing one clock and reset.
module tb_serial_cmp_seq;

   logic clk;
   logic rst;

   serial_cmp_seq_if #(.WIDTH(8))  bus8  ();
   serial_cmp_seq_if #(.WIDTH(2))  bus2  ();
   serial_cmp_seq_if #(.WIDTH(16)) bus16 ();

   serial_cmp_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   serial_cmp_seq #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
   serial_cmp_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 0;

   logic        cur_busy, cur_done, cur_g, cur_e, cur_s;
   logic [31:0] cur_pairs;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs of the instance currently under test.
   always_comb begin
      cur_busy  = bus8.busy;
      cur_done  = bus8.done;
      cur_g     = bus8.g;
      cur_e     = bus8.e;
      cur_s     = bus8.s;
      cur_pairs = 32'(bus8.pairs);
      if (sel == 1) begin
         cur_busy  = bus2.busy;
         cur_done  = bus2.done;
         cur_g     = bus2.g;
         cur_e     = bus2.e;
         cur_s     = bus2.s;
         cur_pairs = 32'(bus2.pairs);
      end else if (sel == 2) begin
         cur_busy  = bus16.busy;
         cur_done  = bus16.done;
         cur_g     = bus16.g;
         cur_e     = bus16.e;
         cur_s     = bus16.s;
         cur_pairs = 32'(bus16.pairs);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input logic [15:0] av, input logic [15:0] bv,
                        input logic st);
      sel         = which;
      bus8.start  = 1'b0;
      bus2.start  = 1'b0;
      bus16.start = 1'b0;
      if (which == 0) begin
         bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.start = st;
      end else if (which == 1) begin
         bus2.a = av[1:0]; bus2.b = bv[1:0]; bus2.start = st;
      end else begin
         bus16.a = av; bus16.b = bv; bus16.start = st;
      end
   endtask

   // One full request; operands are scrambled right after capture.
   task automatic op(input int which, input logic [15:0] av, input logic [15:0] bv,
                     input logic eg, input logic ee, input logic es,
                     input int ep, input int elat, input string tag);
      int lat;
      drive(which, av, bv, 1'b1);
      tick();
      drive(which, ~av, ~bv, 1'b0);
      lat = 1;
      chk({tag, "_busy"}, 32'(cur_busy), 32'd1);
      chk({tag, "_ges_busy"}, 32'({cur_g, cur_e, cur_s}), 32'd0);
      while (cur_done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk({tag, "_done"}, 32'(cur_done), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(elat));
      chk({tag, "_ges"}, 32'({cur_g, cur_e, cur_s}), 32'({eg, ee, es}));
      chk({tag, "_pairs"}, cur_pairs, 32'(ep));
      chk({tag, "_busy_done"}, 32'(cur_busy), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
      chk({tag, "_ges_hold"}, 32'({cur_g, cur_e, cur_s}), 32'({eg, ee, es}));
      chk({tag, "_pairs_hold"}, cur_pairs, 32'(ep));
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 16'h0, 16'h0, 1'b0);
      drive(1, 16'h0, 16'h0, 1'b0);
      drive(2, 16'h0, 16'h0, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         chk("reset_busy_done", 32'({cur_busy, cur_done}), 32'd0);
         chk("reset_ges", 32'({cur_g, cur_e, cur_s}), 32'd0);
         chk("reset_pairs", cur_pairs, 32'd0);
      end
      rst = 1'b0;
      tick();

      op(0, 16'h00C5, 16'h0035, 1'b1, 1'b0, 1'b0, 1, 2, "c5_35");
      op(0, 16'h00A7, 16'h00A7, 1'b0, 1'b1, 1'b0, 4, 5, "a7_a7");
      op(0, 16'h0034, 16'h0036, 1'b0, 1'b0, 1'b1, 4, 5, "34_36");

      // Back-to-back: 0x00 vs 0xFF, ignored start while busy, restart in DONE.
      drive(0, 16'h0000, 16'h00FF, 1'b1);
      tick();
      drive(0, 16'h0000, 16'h0000, 1'b1);
      chk("b2b_busy1", 32'(cur_busy), 32'd1);
      tick();
      chk("b2b_done1", 32'(cur_done), 32'd1);
      chk("b2b_ges1", 32'({cur_g, cur_e, cur_s}), 32'b001);
      chk("b2b_pairs1", cur_pairs, 32'd1);
      drive(0, 16'h00FF, 16'h0000, 1'b1);
      tick();
      drive(0, 16'h0000, 16'h0000, 1'b0);
      chk("b2b_busy2", 32'({cur_busy, cur_done}), 32'b10);
      chk("b2b_cleared", 32'({cur_g, cur_e, cur_s}), 32'd0);
      chk("b2b_pairs_clr", cur_pairs, 32'd0);
      tick();
      chk("b2b_done2", 32'(cur_done), 32'd1);
      chk("b2b_ges2", 32'({cur_g, cur_e, cur_s}), 32'b100);
      chk("b2b_pairs2", cur_pairs, 32'd1);
      tick();
      chk("b2b_idle", 32'({cur_busy, cur_done}), 32'd0);

      // Reset in the second RUN cycle of an equal-operand compare.
      drive(0, 16'h0055, 16'h0055, 1'b1);
      tick();
      drive(0, 16'h0055, 16'h0055, 1'b0);
      tick();
      chk("rst_mid_busy", 32'(cur_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy_done", 32'({cur_busy, cur_done}), 32'd0);
      chk("rst_mid_ges", 32'({cur_g, cur_e, cur_s}), 32'd0);
      chk("rst_mid_pairs", cur_pairs, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_mid_no_done", 32'({cur_busy, cur_done}), 32'd0);
      end
      op(0, 16'h0080, 16'h007F, 1'b1, 1'b0, 1'b0, 1, 2, "80_7f");

      op(1, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1, 2, "w2_10_01");
      op(2, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0, 8, 9, "w16_eq");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
